// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared constants and state type for the pipeline clock-enable controller.
package cpu_clk_ctrl_pkg;

  // Divide ratio loaded at reset when the top-level parameter is not overridden.
  localparam int unsigned COUNTER_MAX    = 32'd50_000_000;

  // Default number of stable samples before the step button level changes.
  localparam int unsigned DEB_CYCLES_DEF = 1_000_000;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_BRK  = 2'd3
  } state_e;

  // The pipeline is considered halted while parked in HALT or at a breakpoint.
  function automatic logic is_halted(input state_e s);
    return (s == ST_HALT) || (s == ST_BRK);
  endfunction

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// single-cycle pulse on the debounced rising edge.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned      CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // Count consecutive samples that differ from the debounced level; adopt the
  // new level once DEB_CYCLES of them have been seen in a row.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    pulse_d = ~level_q & level_d;
  end

  // Synchronizer, debounce state and edge pulse registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/step/breakpoint controller producing a one-cycle clock enable for the
// five-stage pipeline from the board clock.
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int unsigned          CNT_W       = 32,
  parameter logic [CNT_W-1:0]     DEFAULT_DIV = CNT_W'(COUNTER_MAX),
  parameter int unsigned          DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int unsigned          PC_W        = 32
) (
  input  logic             out_clk,
  input  logic             reset_n,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_ce,
  output logic             halted,
  output logic             brk_hit,
  output logic [31:0]      ce_count
);

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] div_q,      div_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             skip_q,     skip_d;
  logic             ce_q,       ce_d;
  logic [31:0]      ce_count_q, ce_count_d;

  logic             step_pulse;
  logic             term;
  logic             bp_match;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_step_deb (
    .clk_i  (out_clk),
    .rst_ni (reset_n),
    .btn_i  (step_btn),
    .pulse_o(step_pulse)
  );

  // Next-state, divider and breakpoint decisions for the control FSM.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = '0;
    skip_d     = skip_q;
    ce_d       = 1'b0;
    ce_count_d = ce_count_q + {31'b0, ce_q};

    // A divide ratio of zero behaves as one: terminal count every cycle.
    term     = (div_q == '0) || (cnt_q == div_q - CNT_W'(1));
    bp_match = bp_en && (pc == bp_addr);

    unique case (state_q)
      ST_HALT: begin
        if (step_pulse) begin
          state_d = ST_STEP;
        end else if (run_sw) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!run_sw || halt_req) begin
          state_d = ST_HALT;
        end else if (div_load) begin
          cnt_d = '0;
        end else if (term) begin
          if (bp_match && !skip_q) begin
            state_d = ST_BRK;
          end else begin
            ce_d   = 1'b1;
            skip_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STEP: begin
        ce_d    = 1'b1;
        state_d = ST_HALT;
      end

      ST_BRK: begin
        // Re-arm runs through HALT: run_sw low parks in HALT with bp_skip set,
        // run_sw high then resumes RUN past the breakpoint instruction once.
        if (step_pulse) begin
          state_d = ST_STEP;
        end else if (!run_sw) begin
          state_d = ST_HALT;
          skip_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_HALT;
      end
    endcase

    if (div_load) begin
      div_d = div_val;
      cnt_d = '0;
    end
  end

  // Control state, divider and enable registers.
  always_ff @(posedge out_clk) begin
    if (!reset_n) begin
      state_q    <= ST_HALT;
      div_q      <= DEFAULT_DIV;
      cnt_q      <= '0;
      skip_q     <= 1'b0;
      ce_q       <= 1'b0;
      ce_count_q <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      skip_q     <= skip_d;
      ce_q       <= ce_d;
      ce_count_q <= ce_count_d;
    end
  end

  assign cpu_ce   = ce_q;
  assign halted   = is_halted(state_q);
  assign brk_hit  = (state_q == ST_BRK);
  assign ce_count = ce_count_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboard bench for cpu_clk_ctrl: expected cpu_ce pulses (cycle number and
// ce_count seen at the pulse) are queued by the stimulus; a monitor pops them.
module tb_cpu_clk_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run_sw;
  logic        step_btn;
  logic        halt_req;
  logic        div_load;
  logic [31:0] div_val;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        cpu_ce;
  logic        halted;
  logic        brk_hit;
  logic [31:0] ce_count;

  typedef struct {
    int          cyc;
    int unsigned idx;
  } exp_t;

  exp_t        q[$];
  int          cyc     = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned exp_idx = 0;

  cpu_clk_ctrl #(
    .CNT_W      (32),
    .DEFAULT_DIV(32'd4),
    .DEB_CYCLES (4),
    .PC_W       (32)
  ) dut (
    .out_clk (clk),
    .reset_n (reset_n),
    .run_sw  (run_sw),
    .step_btn(step_btn),
    .halt_req(halt_req),
    .div_load(div_load),
    .div_val (div_val),
    .bp_en   (bp_en),
    .bp_addr (bp_addr),
    .pc      (pc),
    .cpu_ce  (cpu_ce),
    .halted  (halted),
    .brk_hit (brk_hit),
    .ce_count(ce_count)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ce(input int c);
    exp_t e;
    e.cyc = c;
    e.idx = exp_idx;
    q.push_back(e);
    exp_idx++;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every observed pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (cpu_ce === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL ce_unexpected: pulse at cycle %0d, none expected", cyc);
      end else begin
        e = q.pop_front();
        check("ce_cycle", cyc, e.cyc);
        check("ce_count_at_pulse", ce_count, e.idx);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int b, t, s, u;
    reset_n  = 1'b0;
    run_sw   = 1'b0;
    step_btn = 1'b0;
    halt_req = 1'b0;
    div_load = 1'b0;
    div_val  = '0;
    bp_en    = 1'b1;
    bp_addr  = 32'h10;
    pc       = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_cpu_ce", {31'b0, cpu_ce}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd1);
    check("rst_brk_hit", {31'b0, brk_hit}, 32'd0);
    check("rst_ce_count", ce_count, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Free run at the default ratio of 4: RUN entered at b+1, pulses every 4.
    b = cyc;
    run_sw = 1'b1;
    for (int k = 1; k <= 5; k++) expect_ce(b + 1 + 4 * k);
    wait_until(b + 22);
    check("run_ce_count", ce_count, 32'd5);

    // Divide-ratio loads: 0, 1, then 3; no pulse in any load cycle.
    t = cyc;
    div_load = 1'b1;
    div_val  = 32'd0;
    expect_ce(t + 2); expect_ce(t + 3); expect_ce(t + 4);
    wait_until(t + 1); div_load = 1'b0;
    wait_until(t + 4); div_load = 1'b1; div_val = 32'd1;
    expect_ce(t + 6); expect_ce(t + 7); expect_ce(t + 8);
    wait_until(t + 5); div_load = 1'b0;
    wait_until(t + 8); div_load = 1'b1; div_val = 32'd3;
    expect_ce(t + 12); expect_ce(t + 15); expect_ce(t + 18);
    wait_until(t + 9); div_load = 1'b0;

    // halt_req coincident with terminal count at edge t+21.
    wait_until(t + 20); halt_req = 1'b1;
    wait_until(t + 21); halt_req = 1'b0;
    check("halt_req_halted", {31'b0, halted}, 32'd1);
    check("halt_req_brk", {31'b0, brk_hit}, 32'd0);
    expect_ce(t + 25); expect_ce(t + 28);

    // Breakpoint at 0x10: suppressed tick at t+31, re-arm, skip once, re-hit.
    wait_until(t + 28); pc = 32'h10;
    wait_until(t + 31);
    check("bp_brk_hit", {31'b0, brk_hit}, 32'd1);
    check("bp_halted", {31'b0, halted}, 32'd1);
    run_sw = 1'b0;
    wait_until(t + 32);
    check("bp_rearm_halted", {31'b0, halted}, 32'd1);
    check("bp_rearm_brk", {31'b0, brk_hit}, 32'd0);
    run_sw = 1'b1;
    expect_ce(t + 36);
    wait_until(t + 37);
    check("bp_skip_running", {31'b0, halted}, 32'd0);
    check("bp_skip_brk", {31'b0, brk_hit}, 32'd0);
    wait_until(t + 39);
    check("bp_recheck_brk", {31'b0, brk_hit}, 32'd1);
    run_sw = 1'b0;
    pc     = 32'h0;

    // Single step with a bouncing button, debounced over 4 samples.
    wait_until(t + 40);
    check("step_pre_halted", {31'b0, halted}, 32'd1);
    s = cyc;
    step_btn = 1'b1;
    wait_until(s + 1); step_btn = 1'b0;
    wait_until(s + 2); step_btn = 1'b1;
    expect_ce(s + 10);
    wait_until(s + 9);
    check("step_state_running", {31'b0, halted}, 32'd0);
    wait_until(s + 11);
    check("step_back_halted", {31'b0, halted}, 32'd1);
    wait_until(s + 13); step_btn = 1'b0;
    wait_until(s + 30);
    check("step_ce_count", ce_count, exp_idx);

    // Reset mid-run with ratio 7, on the very edge a tick would fire.
    u = cyc;
    div_load = 1'b1;
    div_val  = 32'd7;
    wait_until(u + 1); div_load = 1'b0; run_sw = 1'b1;
    expect_ce(u + 9);
    wait_until(u + 15); reset_n = 1'b0;
    wait_until(u + 16); reset_n = 1'b1;
    check("midrst_cpu_ce", {31'b0, cpu_ce}, 32'd0);
    check("midrst_halted", {31'b0, halted}, 32'd1);
    check("midrst_brk_hit", {31'b0, brk_hit}, 32'd0);
    check("midrst_ce_count", ce_count, 32'd0);
    exp_idx = 0;
    expect_ce(u + 21);
    wait_until(u + 22);
    check("midrst_default_div_count", ce_count, 32'd1);
    run_sw = 1'b0;

    repeat (5) @(negedge clk);
    check("pending_pulses", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
